// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 pins, frames
// 11-bit PS/2 bytes, and tracks the most recently pressed key from the
// make/break scan-code stream.
module ps2_key_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] datareceived,
    output logic       extended,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       make_pulse,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchronisers
    logic ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;

    // Clock filter and fall strobe
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;

    // Frame FSM
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tocnt_q, tocnt_d;
    logic          bv_q, bv_d;
    logic [7:0]    bout_q, bout_d;
    logic          err_q, err_d;

    // Scan-code decoder
    logic [7:0] dr_q, dr_d;
    logic       ext_q, ext_d;
    logic       pext_q, pext_d;
    logic       pbrk_q, pbrk_d;
    logic       mk_q, mk_d;

    // Two-flop synchronisers on both pins, idling high like the bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ck_s1_q <= 1'b1;
            ck_s2_q <= 1'b1;
            dt_s1_q <= 1'b1;
            dt_s2_q <= 1'b1;
        end else begin
            ck_s1_q <= ps2_clk;
            ck_s2_q <= ck_s1_q;
            dt_s1_q <= ps2_dat;
            dt_s2_q <= dt_s1_q;
        end
    end

    // Filtered level flips on the FILTER_LEN-th consecutive differing sample
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (ck_s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = ck_s2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;
    end

    // Filter state and registered fall strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
        end
    end

    // Frame FSM next state; bit progress only on fall, abort on timeout
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        tocnt_d  = tocnt_q;
        bv_d     = 1'b0;
        bout_d   = bout_q;
        err_d    = 1'b0;

        if (state_q == S_IDLE || fall_q) begin
            tocnt_d = '0;
        end else begin
            tocnt_d = tocnt_q + 1'b1;
        end

        if (state_q != S_IDLE && !fall_q && tocnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            tocnt_d = '0;
        end else if (fall_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!dt_s2_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    shreg_d  = {dt_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = dt_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (dt_s2_q && ((^shreg_q) ^ par_q)) begin
                        bv_d   = 1'b1;
                        bout_d = shreg_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Frame FSM registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tocnt_q  <= '0;
            bv_q     <= 1'b0;
            bout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tocnt_q  <= tocnt_d;
            bv_q     <= bv_d;
            bout_q   <= bout_d;
            err_q    <= err_d;
        end
    end

    // Make/break decoder, acting on the cycle a byte or an error is reported
    always_comb begin
        dr_d   = dr_q;
        ext_d  = ext_q;
        pext_d = pext_q;
        pbrk_d = pbrk_q;
        mk_d   = 1'b0;
        if (bv_q) begin
            if (bout_q == 8'hE0) begin
                pext_d = 1'b1;
            end else if (bout_q == 8'hF0) begin
                pbrk_d = 1'b1;
            end else begin
                if (!pbrk_q) begin
                    if (bout_q != dr_q || pext_q != ext_q) begin
                        dr_d  = bout_q;
                        ext_d = pext_q;
                        mk_d  = (bout_q != 8'h00);
                    end
                end else if (bout_q == dr_q && pext_q == ext_q) begin
                    dr_d  = 8'h00;
                    ext_d = 1'b0;
                end
                pext_d = 1'b0;
                pbrk_d = 1'b0;
            end
        end else if (err_q) begin
            pext_d = 1'b0;
            pbrk_d = 1'b0;
        end
    end

    // Decoder registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dr_q   <= '0;
            ext_q  <= 1'b0;
            pext_q <= 1'b0;
            pbrk_q <= 1'b0;
            mk_q   <= 1'b0;
        end else begin
            dr_q   <= dr_d;
            ext_q  <= ext_d;
            pext_q <= pext_d;
            pbrk_q <= pbrk_d;
            mk_q   <= mk_d;
        end
    end

    assign datareceived = dr_q;
    assign extended     = ext_q;
    assign byte_valid   = bv_q;
    assign byte_out     = bout_q;
    assign make_pulse   = mk_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: a table of PS/2 frames with expected
// decoder state, then timeout, glitch and mid-frame reset sequences.
module tb_ps2_key_receiver;

    localparam int unsigned FL   = 4;
    localparam int unsigned TO   = 400;
    localparam int unsigned HALF = 20;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] datareceived;
    logic       extended;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       make_pulse;
    logic       frame_err;

    ps2_key_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .datareceived(datareceived),
        .extended    (extended),
        .byte_valid  (byte_valid),
        .byte_out    (byte_out),
        .make_pulse  (make_pulse),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_bad  = 0;
    int unsigned nbv    = 0;
    int unsigned nmk    = 0;
    int unsigned nerr   = 0;
    logic [7:0]  last_bo = 8'h00;
    logic        overlap = 1'b0;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (byte_valid) begin
            nbv = nbv + 1;
            last_bo = byte_out;
        end
        if (make_pulse) nmk = nmk + 1;
        if (frame_err) nerr = nerr + 1;
        if (byte_valid && frame_err) overlap = 1'b1;
    end

    typedef struct {
        logic [7:0]  data;
        logic        bad_par;
        logic        bad_stop;
        logic [7:0]  exp_dr;
        logic        exp_ext;
        int unsigned exp_bv;
        int unsigned exp_mk;
        int unsigned exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        ps2_dat = b;
        if (glitch) begin
            cyc(10);
            ps2_clk = 1'b0;
            cyc(2);
            ps2_clk = 1'b1;
            cyc(HALF - 12);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b0;
        if (glitch) begin
            cyc(10);
            ps2_clk = 1'b1;
            cyc(2);
            ps2_clk = 1'b0;
            cyc(HALF - 12);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                              input logic glitch, input int unsigned nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            send_bit(fr[i], glitch);
        end
        ps2_dat = 1'b1;
    endtask

    // Check pulse deltas and decoder state after one frame
    task automatic check_after(input string tag, input int unsigned bv0, input int unsigned mk0,
                               input int unsigned er0, input vec_t v);
        check({tag, ".byte_valid"}, nbv - bv0, v.exp_bv);
        check({tag, ".make_pulse"}, nmk - mk0, v.exp_mk);
        check({tag, ".frame_err"}, nerr - er0, v.exp_err);
        check({tag, ".datareceived"}, {24'h0, datareceived}, {24'h0, v.exp_dr});
        check({tag, ".extended"}, {31'h0, extended}, {31'h0, v.exp_ext});
        if (v.exp_bv != 0) check({tag, ".byte_out"}, {24'h0, last_bo}, {24'h0, v.data});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned bv0, mk0, er0;
        vec_t hv;

        //          data   bp    bs    dr     ext   bv mk er
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0, 1, 1, 0};
        vecs[1]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0, 1, 0, 0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 8'h1C, 1'b0, 1, 0, 0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0, 0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0, 0};
        vecs[5]  = '{8'h75, 1'b0, 1'b0, 8'h75, 1'b1, 1, 1, 0};
        vecs[6]  = '{8'h1B, 1'b0, 1'b0, 8'h1B, 1'b0, 1, 1, 0};
        vecs[7]  = '{8'hE0, 1'b0, 1'b0, 8'h1B, 1'b0, 1, 0, 0};
        vecs[8]  = '{8'hF0, 1'b0, 1'b0, 8'h1B, 1'b0, 1, 0, 0};
        vecs[9]  = '{8'h75, 1'b0, 1'b0, 8'h1B, 1'b0, 1, 0, 0};
        vecs[10] = '{8'h23, 1'b1, 1'b0, 8'h1B, 1'b0, 0, 0, 1};
        vecs[11] = '{8'h23, 1'b0, 1'b1, 8'h1B, 1'b0, 0, 0, 1};
        vecs[12] = '{8'hF0, 1'b0, 1'b0, 8'h1B, 1'b0, 1, 0, 0};
        vecs[13] = '{8'h1B, 1'b1, 1'b0, 8'h1B, 1'b0, 0, 0, 1};
        vecs[14] = '{8'h1B, 1'b0, 1'b0, 8'h1B, 1'b0, 1, 0, 0};
        vecs[15] = '{8'h23, 1'b0, 1'b0, 8'h23, 1'b0, 1, 1, 0};

        reset   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cyc(5);
        reset = 1'b1;
        cyc(1000);
        check("reset.datareceived", {24'h0, datareceived}, 32'h0);
        check("reset.extended", {31'h0, extended}, 32'h0);
        check("reset.byte_out", {24'h0, byte_out}, 32'h0);
        check("reset.byte_valid_cnt", nbv, 0);
        check("reset.make_cnt", nmk, 0);
        check("reset.err_cnt", nerr, 0);

        for (int unsigned i = 0; i < 16; i++) begin
            bv0 = nbv; mk0 = nmk; er0 = nerr;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 1'b0, 11);
            cyc(40);
            check_after($sformatf("vec%0d", i), bv0, mk0, er0, vecs[i]);
        end

        // Abort after start + 4 data bits, then a clean frame
        bv0 = nbv; mk0 = nmk; er0 = nerr;
        send_frame(8'h2B, 1'b0, 1'b0, 1'b0, 5);
        cyc(TO + 100);
        hv = '{8'h00, 1'b0, 1'b0, 8'h23, 1'b0, 0, 0, 1};
        check_after("timeout", bv0, mk0, er0, hv);
        bv0 = nbv; mk0 = nmk; er0 = nerr;
        send_frame(8'h2B, 1'b0, 1'b0, 1'b0, 11);
        cyc(40);
        hv = '{8'h2B, 1'b0, 1'b0, 8'h2B, 1'b0, 1, 1, 0};
        check_after("post_timeout", bv0, mk0, er0, hv);

        // Short glitches on ps2_clk in both phases of every bit
        bv0 = nbv; mk0 = nmk; er0 = nerr;
        send_frame(8'h1B, 1'b0, 1'b0, 1'b1, 11);
        cyc(40);
        hv = '{8'h1B, 1'b0, 1'b0, 8'h1B, 1'b0, 1, 1, 0};
        check_after("glitch", bv0, mk0, er0, hv);

        // Reset mid-frame: outputs clear without waiting for a clock edge
        send_frame(8'h2B, 1'b0, 1'b0, 1'b0, 4);
        #3;
        reset = 1'b0;
        #1;
        check("midreset.datareceived", {24'h0, datareceived}, 32'h0);
        check("midreset.extended", {31'h0, extended}, 32'h0);
        check("midreset.byte_out", {24'h0, byte_out}, 32'h0);
        check("midreset.byte_valid", {31'h0, byte_valid}, 32'h0);
        cyc(5);
        reset = 1'b1;
        cyc(100);
        bv0 = nbv; mk0 = nmk; er0 = nerr;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11);
        cyc(40);
        hv = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0, 1, 1, 0};
        check_after("post_reset", bv0, mk0, er0, hv);

        check("no_overlap", {31'h0, overlap}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
